issue_scoreboard: RTL
=====================

Name: issue_scoreboard

Overview:
- Sequences instruction issue between the instruction decoder and the execute stage.
- Tracks outstanding register-file writes per architectural register and stalls the IF_ID stage on RAW hazards and WAW over-subscription.
- Clears tracked writes on writeback, and runs a fixed-length drain sequence after a pipeline flush.
- Sits beside the decoder; consumes its read/write addresses and write-enable, and drives IF_ID stall.

Parameters:
- PEND_W, 2, width of each per-register outstanding-write counter; max outstanding writes per register = 2^PEND_W-1.
- DRAIN_CYCLES, 3, cycles spent in DRAIN after a flush (>=1).
- CNT_W, 16, width of the stall-cycle statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetN  in  1  asynchronous active-low reset.
- decValid  in  1  decoder presents a valid instruction this cycle.
- decReadAddr1  in  5  rs1 from decoder (0 = unused/x0).
- decReadAddr2  in  5  rs2 from decoder (0 = unused/x0).
- decWriteAddr  in  5  rd from decoder.
- decRegWriteEnable  in  1  instruction writes rd.
- wbValid  in  1  a register write completes this cycle.
- wbWriteAddr  in  5  register written at writeback.
- flush  in  1  pipeline flush request (branch/exception).
- stall  out  1  hold IF_ID and decoder; combinational from state, counters and inputs.
- issue  out  1  instruction accepted this cycle = decValid & ~stall.
- pendingMask  out  32  bit r = 1 when counter[r] != 0; bit 0 always 0.
- stallCount  out  CNT_W  saturating count of cycles with decValid & stall.
- errUnderflow  out  1  sticky: writeback seen for a register with counter 0.

Behaviour:
- Reset (resetN=0, asynchronous):
  - all 31 counters = 0; state = RUN; drain counter = 0.
  - stallCount = 0; errUnderflow = 0; pendingMask = 0.
  - stall = 0 and issue = 0 while reset is held.
- Register x0 is never tracked: counter[0] is constant 0, and reads/writes of address 0 never cause hazards.
- States: RUN, DRAIN.
- RUN: stall = decValid & (rawHit | wawFull).
  - rawHit: (rs1!=0 & cnt[rs1]!=0) | (rs2!=0 & cnt[rs2]!=0).
  - wawFull: decRegWriteEnable & rd!=0 & cnt[rd] == 2^PEND_W-1.
  - decValid=0 gives stall=0.
- Issue update: issue & decRegWriteEnable & rd!=0 increments cnt[rd] at the next edge.
- Writeback update: wbValid & wbWriteAddr!=0 decrements cnt[wbWriteAddr].
  - If cnt is already 0: counter holds at 0 and errUnderflow is set (sticky until reset).
- Same register incremented and decremented in one cycle: counter unchanged, no error.
- Different registers incremented and decremented in one cycle: both updates apply.
- Counters never wrap; saturation is prevented by the wawFull stall.
- Flush in RUN (takes priority over issue and writeback that cycle):
  - at the next edge all counters = 0 and state -> DRAIN, drain counter = DRAIN_CYCLES-1.
  - issue is forced 0 in the flush cycle.
- DRAIN:
  - stall = 1 regardless of decValid; issue = 0; wbValid ignored (no decrement, no underflow error).
  - drain counter decrements each cycle; at 0, state -> RUN at the next edge.
  - flush asserted in DRAIN reloads the drain counter to DRAIN_CYCLES-1.
- stallCount increments when decValid & stall, in either state, and saturates at all-ones.
- Reset asserted mid-DRAIN or mid-stall: immediate return to reset values.
- Latency: hazard check is combinational in the same cycle; counter updates are visible the cycle after issue/writeback.

Optional Feature:
- Macro: ISSUE_SCOREBOARD_WB_BYPASS_EN.
- Defined: a RAW hit on register r is ignored when wbValid & wbWriteAddr==r & cnt[r]==1 in the same cycle, in RUN only. The write-back value is forwarded by the register file, so the instruction issues without a stall cycle.
- Undefined: the stall persists until the cycle after the counter reaches 0.

Test Plan:
- Reset, then decValid with rs1=5, rs2=6, no pending writes -> stall=0, issue=1, pendingMask=0.
- Issue rd=3 with write enable; next cycle decValid rs1=3 -> stall=1 and stallCount increments. wbValid wbWriteAddr=3 -> following cycle stall=0, pendingMask[3]=0. With the bypass macro defined, stall=0 in the wb cycle itself.
- Issue rd=7 three times (PEND_W=2) -> cnt=3. A fourth write to rd=7 -> stall=1 via wawFull. One writeback to 7 -> issue allowed.
- rd=0 with write enable, and rs1=0 -> never stall; pendingMask[0]=0.
- Pending on r4 and r9, assert flush -> next cycle pendingMask=0, stall=1 for exactly 3 cycles, wbValid during that time ignored, then RUN.
- wbValid wbWriteAddr=12 with cnt[12]=0 -> errUnderflow=1 and stays 1; counter stays 0. Also check simultaneous issue rd=12 with wb 12 at cnt=1 -> cnt stays 1.

Source files
------------

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: RAW/WAW issue interlock with per-register write counters and a post-flush drain.
// Define ISSUE_SCOREBOARD_WB_BYPASS_EN to let a register's final writeback clear a RAW hit in the same cycle.
module issue_scoreboard #(
   parameter int PEND_W       = 2,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             decValid,
   input  logic [4:0]       decReadAddr1,
   input  logic [4:0]       decReadAddr2,
   input  logic [4:0]       decWriteAddr,
   input  logic             decRegWriteEnable,
   input  logic             wbValid,
   input  logic [4:0]       wbWriteAddr,
   input  logic             flush,
   output logic             stall,
   output logic             issue,
   output logic [31:0]      pendingMask,
   output logic [CNT_W-1:0] stallCount,
   output logic             errUnderflow
);
   localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [PEND_W-1:0] cnt_q [32];
   logic [PEND_W-1:0] cnt_d [32];
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              err_q, err_d;
   logic              run, wb_hit, raw1, raw2, waw_full, inc, dec;

   assign run    = state_q == RUN;
   assign wb_hit = run & wbValid & (wbWriteAddr != '0);

`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
   assign raw1 = (decReadAddr1 != '0) & (cnt_q[decReadAddr1] != '0)
               & ~(wb_hit & (wbWriteAddr == decReadAddr1) & (cnt_q[decReadAddr1] == PEND_W'(1)));
   assign raw2 = (decReadAddr2 != '0) & (cnt_q[decReadAddr2] != '0)
               & ~(wb_hit & (wbWriteAddr == decReadAddr2) & (cnt_q[decReadAddr2] == PEND_W'(1)));
`else
   assign raw1 = (decReadAddr1 != '0) & (cnt_q[decReadAddr1] != '0);
   assign raw2 = (decReadAddr2 != '0) & (cnt_q[decReadAddr2] != '0);
`endif

   assign waw_full     = decRegWriteEnable & (decWriteAddr != '0) & (cnt_q[decWriteAddr] == CNT_MAX);
   assign stall        = resetN & (run ? decValid & (raw1 | raw2 | waw_full) : 1'b1);
   assign issue        = resetN & decValid & ~stall & ~flush;
   assign stallCount   = stall_cnt_q;
   assign errUnderflow = err_q;

   // Flush wipes all tracking; a same-cycle increment and decrement cancel without flagging underflow.
   always_comb begin
      state_d     = flush ? DRAIN : (!run && drain_q == '0) ? RUN : state_q;
      drain_d     = flush ? DRAIN_LOAD : (!run && drain_q != '0) ? drain_q - DW'(1) : drain_q;
      stall_cnt_d = (decValid & stall & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      err_d       = err_q;
      inc         = 1'b0;
      dec         = 1'b0;
      cnt_d[0]    = '0;
      pendingMask = '0;
      for (int r = 1; r < 32; r++) begin
         inc            = issue & decRegWriteEnable & (decWriteAddr == 5'(r));
         dec            = wb_hit & ~flush & (wbWriteAddr == 5'(r));
         err_d          = err_d | (dec & ~inc & (cnt_q[r] == '0));
         cnt_d[r]       = flush ? '0
                        : (inc & ~dec) ? cnt_q[r] + PEND_W'(1)
                        : (dec & ~inc & cnt_q[r] != '0) ? cnt_q[r] - PEND_W'(1)
                        : cnt_q[r];
         pendingMask[r] = cnt_q[r] != '0;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= RUN;
         drain_q     <= '0;
         cnt_q       <= '{default: '0};
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end
endmodule
